// File: rtl/ctrl_debounce_decoder_pkg.sv
// Shared constants and helpers for the debounced control decoder.
package ctrl_debounce_decoder_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE = 16;

  localparam bit MODE_LEVEL  = 1'b0;
  localparam bit MODE_TOGGLE = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ctrl_debounce_decoder_chan.sv
// One control channel: 2-flop synchroniser, debounce counter, stable/toggle state
// and registered rise/fall strobes.
module ctrl_debounce_decoder_chan
  import ctrl_debounce_decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
  parameter bit          TOGGLE   = MODE_LEVEL
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  input  logic tgl_clr_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);

  localparam int unsigned CntW = (clog2(DEBOUNCE) < 1) ? 1 : clog2(DEBOUNCE);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            tg_q, tg_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            accept;

  always_comb begin
    s1_d     = din_i;
    s2_d     = s1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    tg_d     = tg_q;
    accept   = 1'b0;

    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      accept   = 1'b1;
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    rise_d = accept & s2_q;
    fall_d = accept & ~s2_q;

    // Only presses toggle; a clear overrides a same-cycle press.
    if (accept && s2_q) begin
      tg_d = ~tg_q;
    end
    if (tgl_clr_i) begin
      tg_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      tg_q     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      tg_q     <= tg_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign out_o    = (TOGGLE == MODE_TOGGLE) ? tg_q : stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign accept_o = accept;

endmodule

// File: rtl/ctrl_debounce_decoder.sv
// Debounced control decoder: WIDTH independent channels, level or toggle per channel,
// with registered rise/fall strobes and an aggregate change flag.
module ctrl_debounce_decoder
  import ctrl_debounce_decoder_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      DEBOUNCE    = DEFAULT_DEBOUNCE,
  parameter logic [WIDTH-1:0] TOGGLE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ctrl_in,
  input  logic             tgl_clr,
  output logic [WIDTH-1:0] ctrl_out,
  output logic [WIDTH-1:0] ctrl_rise,
  output logic [WIDTH-1:0] ctrl_fall,
  output logic             changed
);

  logic [WIDTH-1:0] accept;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    ctrl_debounce_decoder_chan #(
      .DEBOUNCE (DEBOUNCE),
      .TOGGLE   (TOGGLE_MASK[i])
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .din_i     (ctrl_in[i]),
      .tgl_clr_i (tgl_clr),
      .out_o     (ctrl_out[i]),
      .rise_o    (ctrl_rise[i]),
      .fall_o    (ctrl_fall[i]),
      .accept_o  (accept[i])
    );
  end

  // Every accept yields exactly one rise or fall, so this lines up with the strobes.
  always_comb begin
    changed_d = |accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule
